// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: coefficient width, per-MOD_INDEX moduli and loader state encoding.
package ntt_pkg;
    localparam int COEFF_WIDTH = 30;
    localparam int NUM_MODS    = 4;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_FILL  = 2'd1,
        LD_FLUSH = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_e;

    // Unknown indices fall back to the first modulus so a bad index still yields a legal Q.
    function automatic int unsigned q_for_index(input int unsigned mod_index);
        case (mod_index)
            32'd1:   return 32'd1071513601;
            32'd2:   return 32'd1070727169;
            32'd3:   return 32'd1069547521;
            default: return 32'd1073479681;
        endcase
    endfunction
endpackage

// File: rtl/ntt_core_loader_if.sv
// Coefficient stream into the loader plus the loader's write port into ntt_core.
interface ntt_core_loader_if #(
    parameter int COEFF_WIDTH = 30,
    parameter int ADDR_WIDTH  = 9
) ();
    logic [COEFF_WIDTH-1:0]   in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic                     write_enable;
    logic [ADDR_WIDTH-1:0]    upper_write_address;
    logic [ADDR_WIDTH-1:0]    lower_write_address;
    logic [2*COEFF_WIDTH-1:0] upper_data_input;
    logic [2*COEFF_WIDTH-1:0] lower_data_input;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, write_enable, upper_write_address, lower_write_address,
               upper_data_input, lower_data_input
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, write_enable, upper_write_address, lower_write_address,
               upper_data_input, lower_data_input
    );
endinterface

// File: rtl/mod_cond_sub.sv
// Conditional subtract: y = x - Q when x >= Q, else x. Combinational, valid for x < 2Q.
module mod_cond_sub #(
    parameter int          COEFF_WIDTH = 30,
    parameter int unsigned Q           = 32'd1073479681
) (
    input  logic [COEFF_WIDTH-1:0] x_i,
    output logic [COEFF_WIDTH-1:0] y_o
);
    localparam logic [COEFF_WIDTH-1:0] QW = COEFF_WIDTH'(Q);

    assign y_o = (x_i >= QW) ? (x_i - QW) : x_i;
endmodule

// File: rtl/ntt_core_loader.sv
// Streams coefficients into ntt_core: reduce mod Q, pack four per address, one write per four beats.
// Write lands the cycle after the 4th beat; done two cycles after the last beat; no input bubbles in FILL.
module ntt_core_loader
    import ntt_pkg::loader_state_e, ntt_pkg::LD_IDLE, ntt_pkg::LD_FILL, ntt_pkg::LD_FLUSH, ntt_pkg::LD_DONE;
#(
    parameter int          COEFF_WIDTH = ntt_pkg::COEFF_WIDTH,
    parameter int          ADDR_WIDTH  = 9,
    parameter int          WORDS       = 512,
    parameter int unsigned Q           = ntt_pkg::q_for_index(0)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    ntt_core_loader_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic             error
);
    loader_state_e            state_q, state_d;
    logic [1:0]               beat_q;
    logic [ADDR_WIDTH-1:0]    word_q;
    logic [COEFF_WIDTH-1:0]   up_lo_q, up_hi_q, lo_lo_q, red;
    logic [2*COEFF_WIDTH-1:0] wr_upper_q, wr_lower_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic                     we_q, error_q;
    logic                     accept, start_ok, last_slot, final_beat;

    mod_cond_sub #(.COEFF_WIDTH(COEFF_WIDTH), .Q(Q)) u_reduce (
        .x_i (bus.in_data),
        .y_o (red)
    );

    assign start_ok   = start && (state_q == LD_IDLE || state_q == LD_DONE);
    assign accept     = bus.in_valid && (state_q == LD_FILL);
    assign last_slot  = (beat_q == 2'd3);
    assign final_beat = last_slot && (word_q == ADDR_WIDTH'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= LD_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE, LD_DONE: if (start) state_d = LD_FILL;
            LD_FILL: begin
                if (accept) begin
                    if (final_beat)       state_d = LD_FLUSH;
                    else if (bus.in_last) state_d = LD_DONE;
                end
            end
            LD_FLUSH: state_d = LD_DONE;
            default:  state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            LD_FILL:  begin bus.in_ready = 1'b1; busy = 1'b1; end
            LD_FLUSH: busy = 1'b1;
            LD_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= 2'd0;
            word_q     <= '0;
            up_lo_q    <= '0;
            up_hi_q    <= '0;
            lo_lo_q    <= '0;
            wr_upper_q <= '0;
            wr_lower_q <= '0;
            wr_addr_q  <= '0;
            we_q       <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start_ok) begin
                beat_q  <= 2'd0;
                word_q  <= '0;
                error_q <= 1'b0;
            end else if (accept) begin
                beat_q <= beat_q + 2'd1;
                case (beat_q)
                    2'd0:    up_lo_q <= red;
                    2'd1:    up_hi_q <= red;
                    2'd2:    lo_lo_q <= red;
                    default: ;
                endcase
                // Early in_last drops the partial word; a missing one still writes the final word.
                if (final_beat || (last_slot && !bus.in_last)) begin
                    we_q       <= 1'b1;
                    wr_addr_q  <= word_q;
                    wr_upper_q <= {up_hi_q, up_lo_q};
                    wr_lower_q <= {red, lo_lo_q};
                end
                if (final_beat)       error_q <= !bus.in_last;
                else if (bus.in_last) error_q <= 1'b1;
                else if (last_slot)   word_q  <= word_q + ADDR_WIDTH'(1);
            end
        end
    end

    // A write still pending when reset arrives is suppressed at the core.
    assign bus.write_enable        = we_q && !rst;
    assign bus.upper_write_address = wr_addr_q;
    assign bus.lower_write_address = wr_addr_q;
    assign bus.upper_data_input    = wr_upper_q;
    assign bus.lower_data_input    = wr_lower_q;
    assign error                   = error_q;
endmodule
